// File: rtl/alu_pipe_pkg.sv
// Shared op codes and FSM state encoding for the pipelined ALU.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ROL = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRA = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_pipe_comb.sv
// Single-cycle datapath: operand inversion, shifter/rotator, logic ops, adder and overflow.
// MUL and reserved codes yield zero here; the multiply result comes from the top.
module alu_pipe_comb
    import alu_pipe_pkg::*;
#(
    parameter  int N  = 16,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic [3:0]   op,
    input  logic         inv_a,
    input  logic         inv_b,
    input  logic         sign,
    output logic [N-1:0] act_a,
    output logic [N-1:0] act_b,
    output logic [N-1:0] result,
    output logic         ofl
);

    logic [CW-1:0] sh;
    logic [CW:0]   sh_rev;
    logic [N:0]    sum;
    logic          add_ofl;

    assign act_a = inv_a ? ~a : a;
    assign act_b = inv_b ? ~b : b;

    // A zero count gives sh_rev == N, which shifts the wrap-around term out entirely.
    assign sh     = act_b[CW-1:0];
    assign sh_rev = (CW+1)'(N) - {1'b0, sh};

    assign sum     = {1'b0, act_a} + {1'b0, act_b} + {{N{1'b0}}, cin};
    assign add_ofl = sign ? ((act_a[N-1] == act_b[N-1]) && (sum[N-1] != act_a[N-1]))
                          : sum[N];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        result = '0;
        ofl    = 1'b0;
        case (op)
            OP_ROL: result = (act_a << sh) | (act_a >> sh_rev);
            OP_ROR: result = (act_a >> sh) | (act_a << sh_rev);
            OP_SLL: result = act_a << sh;
            OP_SRL: result = act_a >> sh;
            OP_SRA: result = $unsigned($signed(act_a) >>> sh);
            OP_ADD: begin
                result = sum[N-1:0];
                ofl    = add_ofl;
            end
            OP_OR:  result = act_a | act_b;
            OP_XOR: result = act_a ^ act_b;
            OP_AND: result = act_a & act_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready on both sides and an N-cycle iterative multiply.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter  int N  = 16,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] InA,
    input  logic [N-1:0] InB,
    input  logic         Cin,
    input  logic [3:0]   Op,
    input  logic         invA,
    input  logic         invB,
    input  logic         sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Out,
    output logic         Zero,
    output logic         Ofl,
    output logic         ofl_sticky,
    input  logic         clr_sticky,
    output logic         busy
);

    state_t         state, state_next;
    logic [N-1:0]   act_a, act_b, comb_res;
    logic           comb_ofl;
    logic [N-1:0]   mag_a, mag_b, mplier;
    logic [2*N-1:0] acc, mcand, acc_step, prod;
    logic [CW-1:0]  cnt;
    logic           neg, msign, mul_ofl;
    logic           accept, accept_mul, mul_last;

    alu_pipe_comb #(.N(N)) u_comb (
        .a      (InA),
        .b      (InB),
        .cin    (Cin),
        .op     (Op),
        .inv_a  (invA),
        .inv_b  (invB),
        .sign   (sign),
        .act_a  (act_a),
        .act_b  (act_b),
        .result (comb_res),
        .ofl    (comb_ofl)
    );

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign busy       = (state == MUL);
    assign accept     = in_valid && in_ready;
    assign accept_mul = accept && (Op == OP_MUL);
    assign mul_last   = (state == MUL) && (cnt == '0);
    assign Zero       = (Out == '0);

    // Signed multiply runs on magnitudes; the sign is reapplied to the full 2N product.
    assign mag_a    = (sign && act_a[N-1]) ? -act_a : act_a;
    assign mag_b    = (sign && act_b[N-1]) ? -act_b : act_b;
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign prod     = neg ? -acc_step : acc_step;
    assign mul_ofl  = msign ? (prod[2*N-1:N] != {N{prod[N-1]}}) : (|prod[2*N-1:N]);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mul) state_next = MUL;
            MUL:     if (cnt == '0)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            msign  <= 1'b0;
        end else if (accept_mul) begin
            cnt    <= CW'(N - 1);
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sign && (act_a[N-1] ^ act_b[N-1]);
            msign  <= sign;
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Out        <= '0;
            Ofl        <= 1'b0;
            out_valid  <= 1'b0;
            ofl_sticky <= 1'b0;
        end else begin
            if (accept && !accept_mul) begin
                Out       <= comb_res;
                Ofl       <= comb_ofl;
                out_valid <= 1'b1;
            end else if (mul_last) begin
                Out       <= prod[N-1:0];
                Ofl       <= mul_ofl;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready && Ofl) ofl_sticky <= 1'b1;
            else if (clr_sticky)               ofl_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe, checked against a transaction-level model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [N-1:0]  InA = '0, InB = '0;
    logic          Cin = 1'b0, invA = 1'b0, invB = 1'b0, sign = 1'b0;
    logic [3:0]    Op = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [N-1:0]  Out;
    logic          Zero, Ofl, ofl_sticky, busy;
    logic          clr_sticky = 1'b0;

    typedef struct {
        logic [15:0] out;
        logic        ofl;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, mul_end = 0;
    logic        sticky_m = 1'b0, rand_on = 1'b0;
    logic        ov_e, busy_e, ir_e, set_e;
    logic [16:0] r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_pipe #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .InA(InA), .InB(InB), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB),
        .sign(sign), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
        .Zero(Zero), .Ofl(Ofl), .ofl_sticky(ofl_sticky), .clr_sticky(clr_sticky),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Returns {ofl, out}, computed with plain integer arithmetic on 16-bit values.
    function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin,
                                            input logic ia, input logic ib, input logic sg);
        logic [15:0] xa, yb, res;
        int unsigned x, y, c, s;
        int          sx, sy, ss;
        longint      p;
        logic        o;
        xa = ia ? ~a : a;
        yb = ib ? ~b : b;
        x = xa; y = yb; c = y % 16;
        sx = int'($signed(xa)); sy = int'($signed(yb));
        res = '0; o = 1'b0;
        case (op)
            OP_ROL: res = 16'((x << c) | (x >> (16 - c)));
            OP_ROR: res = 16'((x >> c) | (x << (16 - c)));
            OP_SLL: res = 16'(x << c);
            OP_SRL: res = 16'(x >> c);
            OP_SRA: res = 16'(sx >>> c);
            OP_ADD: begin
                s   = x + y + cin;
                ss  = sx + sy + int'(cin);
                res = 16'(s);
                o   = sg ? (ss > 32767 || ss < -32768) : (s > 65535);
            end
            OP_OR:  res = xa | yb;
            OP_XOR: res = xa ^ yb;
            OP_AND: res = xa & yb;
            OP_MUL: begin
                if (sg) begin
                    p = longint'(sx) * longint'(sy);
                    o = (p > 32767) || (p < -32768);
                end else begin
                    p = longint'(x) * longint'(y);
                    o = (p > 65535);
                end
                res = 16'(p);
            end
            default: ;
        endcase
        return {o, res};
    endfunction

    // Cycle-level model: expected output slot, busy window and sticky flag.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mul_end  = 0;
            sticky_m = 1'b0;
        end else begin
            ov_e   = (q.size() > 0) && (q[0].rdy <= cyc);
            busy_e = cyc < mul_end;
            ir_e   = !busy_e && (!ov_e || out_ready);
            check("out_valid", out_valid, ov_e);
            check("busy", busy, busy_e);
            check("in_ready", in_ready, ir_e);
            check("ofl_sticky", ofl_sticky, sticky_m);
            if (ov_e) begin
                check("out", Out, q[0].out);
                check("ofl", Ofl, q[0].ofl);
                check("zero", Zero, q[0].out == 16'h0);
            end
            set_e = ov_e && out_ready && q[0].ofl;
            if (set_e)           sticky_m = 1'b1;
            else if (clr_sticky) sticky_m = 1'b0;
            if (ov_e && out_ready) void'(q.pop_front());
            if (in_valid && ir_e) begin
                r     = ref_alu(Op, InA, InB, Cin, invA, invB, sign);
                e.out = r[15:0];
                e.ofl = r[16];
                e.rdy = cyc + 1 + ((Op == OP_MUL) ? N : 0);
                q.push_back(e);
                if (Op == OP_MUL) mul_end = cyc + 1 + N;
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic ia, input logic ib, input logic sg);
        Op = op; InA = a; InB = b; Cin = c; invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp_out, input logic exp_ofl,
                            output int busy_n);
        busy_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) busy_n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check(tag, Out, exp_out);
        check({tag, "_ofl"}, Ofl, exp_ofl);
        check({tag, "_zero"}, Zero, exp_out == 16'h0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bn;
        logic [3:0] rop;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out", Out, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        // Signed ADD overflow, then sticky set on consumption.
        drive(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_out("add_sovf", 16'h8000, 1'b1, bn);
        @(negedge clk);
        check("sticky_set", ofl_sticky, 1);
        @(posedge clk); #1 clr_sticky = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;

        // Shifts and rotates.
        drive(OP_SRA, 16'h8000, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out("sra", 16'hF800, 1'b0, bn);
        drive(OP_ROR, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out("ror", 16'h8000, 1'b0, bn);
        drive(OP_SLL, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out("sll0", 16'h1234, 1'b0, bn);

        // Multiplies.
        drive(OP_MUL, 16'hFFFD, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_out("mul_s", 16'hFFF1, 1'b0, bn);
        check("mul_busy_cycles", bn, 16);
        drive(OP_MUL, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out("mul_u", 16'h0000, 1'b1, bn);

        // Backpressure: result held, second bundle accepted on the draining edge.
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_out", Out, 16'h0003);
        check("hold_ready", in_ready, 0);
        @(posedge clk); #1;
        fork
            drive(OP_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_out("b2b_second", 16'h0007, 1'b0, bn);

        // Reset in the middle of a multiply.
        drive(OP_MUL, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        @(posedge clk); #1;
        drive(OP_XOR, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out("xor", 16'hFFFF, 1'b0, bn);

        // Sticky: set beats clear on the same edge, then clear alone.
        out_ready = 1'b0;
        drive(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", ofl_sticky, 1);
        @(posedge clk); #1 clr_sticky = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_cleared", ofl_sticky, 0);
        @(posedge clk); #1;
        drive(4'b1111, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_out("reserved", 16'h0000, 1'b0, bn);

        // Random traffic with random backpressure and sticky clears.
        rand_on = 1'b1;
        fork
            begin
                for (int t = 0; t < 400; t++) begin
                    rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    drive(rop, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #2;
                    out_ready  = ($urandom_range(0, 3) != 0);
                    clr_sticky = ($urandom_range(0, 15) == 0);
                end
            end
        join
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, handshaked successor to the 16-bit combinational ALU, parametrised in data width.
- Adds a rotate-right op, a multi-cycle iterative multiply, and a sticky overflow flag.
- Sits between the decode/operand-read stage and writeback.
- Uses valid/ready on both sides, so a multiply stalls the upstream stage cleanly.

Parameters:
N, 16, data width; power of two, N >= 4
CW, $clog2(N), shift-count width; derived, not overridden

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept a bundle this cycle
InA  input  N  operand A
InB  input  N  operand B
Cin  input  1  carry-in for ADD
Op  input  4  operation select
invA  input  1  invert A before operation
invB  input  1  invert B before operation
sign  input  1  1 = signed overflow rules, 0 = unsigned
out_valid  output  1  result registers valid
out_ready  input  1  consumer takes the result this cycle
Out  output  N  result
Zero  output  1  Out == 0
Ofl  output  1  overflow for this result
ofl_sticky  output  1  OR of Ofl over all consumed results since clear
clr_sticky  input  1  clear ofl_sticky
busy  output  1  multiply in progress

Behaviour:
- Operand preparation: actA = invA ? ~InA : InA; actB = invB ? ~InB : InB. Inversion applies to every op.
- Op encoding:
  - 0000 rotate left; 0001 shift left; 0010 shift right arith; 0011 shift right logical.
  - 0100 ADD (actA+actB+Cin); 0101 OR; 0110 XOR; 0111 AND.
  - 1000 MUL (low N bits of actA*actB); 1001 rotate right.
  - 1010-1111 reserved: Out=0, Ofl=0.
- Shift/rotate count is actB[CW-1:0]; count 0 returns actA unchanged.
- ADD Ofl:
  - sign=1: operands share a sign bit and the sum sign differs.
  - sign=0: carry out of bit N-1.
- MUL Ofl:
  - sign=0: any of the upper N bits of the 2N product is nonzero.
  - sign=1: operands are treated as two's complement; Ofl if the 2N product is not the sign extension of its low N bits.
- Ofl=0 for all ops other than ADD and MUL. Zero is derived from the Out register, never from unregistered logic.
- Handshake: input is accepted on an edge with in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so the output slot drains and refills in the same cycle.
- FSM states: IDLE, MUL.
  - IDLE, accept non-MUL op: Out/Ofl registered on the accept edge; out_valid=1 next cycle. Latency 1, throughput 1 per cycle.
  - IDLE, accept MUL: capture |actA|, |actB| (when sign=1) plus result sign, clear the 2N accumulator, cnt=N-1, go to MUL, busy=1.
  - MUL: one shift-add step per edge. After the step with cnt==0, write Out/Ofl and set out_valid. Return to IDLE on that same edge; busy=0. The result is visible N cycles after the accept edge.
  - MUL entry requires the output slot to be free or draining, so the multiply result never overwrites an unconsumed result.
- out_valid clears on an edge with out_ready && out_valid unless a new result is written on the same edge (the new result wins).
- Out and Ofl hold stable while out_valid && !out_ready.
- ofl_sticky:
  - Set on an edge where out_valid && out_ready && Ofl.
  - clr_sticky clears it.
  - On a simultaneous set and clr, the set wins.
- Reset:
  - Out=0, Ofl=0, out_valid=0, ofl_sticky=0, state=IDLE, busy=0, cnt=0.
  - in_ready=1 after reset, from the first post-reset cycle.
  - Reset during MUL aborts the multiply; no result is produced.
- in_valid while !in_ready is ignored; the bundle is not captured, and upstream must hold it.

Decomposition:
- Package alu_pipe_pkg holds:
  - The 4-bit op codes (OP_ROL, OP_SLL, OP_SRA, OP_SRL, OP_ADD, OP_OR, OP_XOR, OP_AND, OP_MUL, OP_ROR).
  - The FSM state encoding.
- One sub-module, alu_pipe_comb: parametrised combinational single-cycle datapath (inversion, shifter, logic, adder, Ofl).
- The top holds the handshake, the FSM, the multiply accumulator/counter and the output registers.

Test Plan:
1. N=16, ADD, InA=0x7FFF, InB=0x0001, Cin=0, sign=1, out_ready=1 -> next cycle out_valid=1, Out=0x8000, Ofl=1, Zero=0, ofl_sticky=1 the following cycle.
2. SRA InA=0x8000 InB=0x0004 -> Out=0xF800. ROR InA=0x0001 InB=0x0001 -> Out=0x8000. SLL with count 0 -> Out=InA.
3. MUL, sign=1, InA=0xFFFD (-3), InB=0x0005 -> in_ready=0 and busy=1 for 16 cycles; Out=0xFFF1, Ofl=0. Then sign=0, InA=0x0100, InB=0x0100 -> Out=0x0000, Zero=1, Ofl=1.
4. Back-to-back ADDs with out_ready held 0 for 3 cycles -> Out stable, in_ready=0. Raise out_ready -> first result consumed and second accepted on the same edge; no bundle lost or duplicated.
5. Assert rst at cycle 5 of a MUL -> next cycle out_valid=0, busy=0, in_ready=1. A subsequent XOR 0xAAAA^0x5555 gives Out=0xFFFF.
6. clr_sticky and a consumed Ofl=1 result on the same edge -> ofl_sticky=1. clr_sticky alone -> 0. Reserved op 1111 -> Out=0, Ofl=0, Zero=1.
